regs_shift_bank: RTL and testbench

//  - Parametrised register bank: DEPTH entries of WIDTH bits, organised as a shift chain.
//  - Push inserts at entry 0 (head) and shifts every entry down by one; a length counter tracks valid entries.
//  - Adds synchronous flush, grow/saturate, an indexed read and an associative probe.
//  - Stores ordered history such as snake body coordinates; replaces banks of fixed 8-bit registers.

---
 rtl/regs_shift_bank_pkg.sv | 24 ++
 rtl/regs_shift_bank_if.sv | 40 ++++
 rtl/regs_nbit.sv | 36 +++
 rtl/regs_shift_bank.sv | 109 ++++++++++
 tb/tb_regs_shift_bank.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/regs_shift_bank_pkg.sv
// -----------------------------------------------------------------------------
// regs_shift_bank_pkg
// Shared definitions for the shift-chain register bank:
//   - SNAKE_COORD_W : default entry width (one packed snake coordinate)
//   - len_w_for()   : length-counter width able to hold 0..depth inclusive
//   - op_e          : per-edge operation selected by the flush > push > hold
//                     priority
// -----------------------------------------------------------------------------
package regs_shift_bank_pkg;

  localparam int SNAKE_COORD_W = 8;

  // The counter must reach DEPTH itself (bank full), hence depth+1 states.
  function automatic int len_w_for(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_FLUSH = 2'd1,
    OP_PUSH  = 2'd2
  } op_e;

endpackage

// File: rtl/regs_shift_bank_if.sv
// -----------------------------------------------------------------------------
// regs_shift_bank_if
// Control/data bundle of the shift-chain register bank.
//   master : drives flush/push/grow/din/rd_idx/probe, observes the status
//   slave  : the bank itself
// Signals:
//   flush, push, grow   operation requests sampled at the rising clock edge
//   din                 data shifted into entry 0 on push
//   rd_idx / rd_data    indexed read (0 = head), combinational
//   probe / hit         associative match against valid entries, combinational
//   head, len, full, empty, ovf  bank status
// -----------------------------------------------------------------------------
interface regs_shift_bank_if #(
  parameter int WIDTH = regs_shift_bank_pkg::SNAKE_COORD_W,
  parameter int LEN_W = 5
);
  logic             flush;
  logic             push;
  logic             grow;
  logic [WIDTH-1:0] din;
  logic [LEN_W-1:0] rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] probe;
  logic             hit;
  logic [WIDTH-1:0] head;
  logic [LEN_W-1:0] len;
  logic             full;
  logic             empty;
  logic             ovf;

  modport master (
    output flush, push, grow, din, rd_idx, probe,
    input  rd_data, hit, head, len, full, empty, ovf
  );

  modport slave (
    input  flush, push, grow, din, rd_idx, probe,
    output rd_data, hit, head, len, full, empty, ovf
  );
endinterface

// File: rtl/regs_nbit.sv
// -----------------------------------------------------------------------------
// regs_nbit
// One WIDTH-bit storage register with load enable.
//   clk    rising-edge clock
//   clear  asynchronous active-high clear (q_o -> 0 immediately)
//   en_i   load d_i at the next rising edge
//   d_i    next value
//   q_o    stored value
// -----------------------------------------------------------------------------
module regs_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // NOTE: storage is cleared on reset here because clear must make every
  // entry read as zero at once; for a true RAM macro this would be dropped.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      data_q <= '0;
    end else if (en_i) begin
      // NOTE: non-blocking so every entry samples its neighbour's pre-edge
      // value; blocking here would smear one value down the whole chain.
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/regs_shift_bank.sv
// -----------------------------------------------------------------------------
// regs_shift_bank
// DEPTH x WIDTH register bank organised as a shift chain with a length
// counter: push inserts at entry 0 and moves the body down one place, grow
// lengthens the valid region, flush empties it.
// Ports:
//   clk    rising-edge clock
//   clear  asynchronous active-high reset (entries, len, ovf -> 0)
//   bus    regs_shift_bank_if.slave (requests, read/probe, status)
// Reads (rd_data, hit, head) are combinational from the current state and
// only ever expose entries with index < len.
// -----------------------------------------------------------------------------
module regs_shift_bank
  import regs_shift_bank_pkg::*;
#(
  parameter int WIDTH = SNAKE_COORD_W,
  parameter int DEPTH = 16,
  parameter int LEN_W = len_w_for(DEPTH)
) (
  input  logic              clk,
  input  logic              clear,
  regs_shift_bank_if.slave  bus
);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             full;
  logic             load;
  op_e              op;

  assign full = (len_q == LEN_W'(DEPTH));

  always_comb begin
    op = OP_HOLD;
    if (bus.flush)     op = OP_FLUSH;
    else if (bus.push) op = OP_PUSH;
  end

  // Flush is a synchronous load of zeros through the same enable as a shift.
  assign load = (op != OP_HOLD);

  for (genvar g = 0; g < DEPTH; g++) begin : g_chain
    if (g == 0) begin : g_head
      assign entry_d[g] = (op == OP_FLUSH) ? '0 : bus.din;
    end else begin : g_body
      assign entry_d[g] = (op == OP_FLUSH) ? '0 : entry_q[g-1];
    end

    regs_nbit #(.WIDTH(WIDTH)) u_entry (
      .clk   (clk),
      .clear (clear),
      .en_i  (load),
      .d_i   (entry_d[g]),
      .q_o   (entry_q[g])
    );
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    len_d = len_q;
    ovf_d = 1'b0;
    unique case (op)
      OP_FLUSH: len_d = '0;
      OP_PUSH: begin
        if (len_q == '0)          len_d = LEN_W'(1);
        else if (bus.grow && !full) len_d = len_q + LEN_W'(1);
        else if (bus.grow)          ovf_d = 1'b1; // grow into a full bank
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  // Index compare is done per entry so rd_idx beyond DEPTH (or beyond len)
  // simply selects nothing and the output stays zero.
  logic [WIDTH-1:0] rd_data;
  logic             hit;
  always_comb begin
    rd_data = '0;
    hit     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LEN_W'(i) < len_q) begin
        if (LEN_W'(i) == bus.rd_idx) rd_data = entry_q[i];
        if (entry_q[i] == bus.probe) hit = 1'b1;
      end
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.hit     = hit;
  assign bus.head    = (len_q == '0) ? '0 : entry_q[0];
  assign bus.len     = len_q;
  assign bus.full    = full;
  assign bus.empty   = (len_q == '0);
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_regs_shift_bank.sv
// -----------------------------------------------------------------------------
// tb_regs_shift_bank
// Self-checking bench for regs_shift_bank (DEPTH=4). The reference model keeps
// the push history as a queue (front = newest) plus a length; visible entry i
// is history[i] when i < len, else zero.
// -----------------------------------------------------------------------------
module tb_regs_shift_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LEN_W = 3;

  logic clk = 1'b0;
  logic clear;
  always #50 clk = ~clk;

  regs_shift_bank_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  regs_shift_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] hist[$];
  int               mlen;
  logic             movf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_entry(input int i);
    if (i < mlen && i < hist.size()) return hist[i];
    return '0;
  endfunction

  function automatic logic exp_hit(input logic [WIDTH-1:0] p);
    for (int i = 0; i < mlen && i < hist.size(); i++)
      if (hist[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    mlen = 0;
    movf = 1'b0;
  endtask

  // Full status, every read index (including beyond DEPTH) and a few probes.
  task automatic check_state(input string tag);
    logic [WIDTH-1:0] p;
    check({tag, ".len"},   32'(bus.len),   32'(mlen));
    check({tag, ".full"},  32'(bus.full),  32'(mlen == DEPTH));
    check({tag, ".empty"}, 32'(bus.empty), 32'(mlen == 0));
    check({tag, ".head"},  32'(bus.head),  32'(exp_entry(0)));
    check({tag, ".ovf"},   32'(bus.ovf),   32'(movf));
    for (int i = 0; i < 8; i++) begin
      bus.rd_idx = LEN_W'(i);
      #1;
      check($sformatf("%s.rd%0d", tag, i), 32'(bus.rd_data), 32'(exp_entry(i)));
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      p = (i < hist.size()) ? hist[i] : WIDTH'($urandom);
      bus.probe = p;
      #1;
      check($sformatf("%s.hit%0h", tag, p), 32'(bus.hit), 32'(exp_hit(p)));
    end
  endtask

  // One clock cycle of requests; called in the low phase of the clock.
  task automatic step(input string tag, input logic f, input logic p,
                      input logic g, input logic [WIDTH-1:0] d);
    bus.flush = f;
    bus.push  = p;
    bus.grow  = g;
    bus.din   = d;
    bus.probe = d;
    #1;
    check({tag, ".prehit"}, 32'(bus.hit), 32'(exp_hit(d)));
    @(posedge clk);
    movf = 1'b0;
    if (f) begin
      hist.delete();
      mlen = 0;
    end else if (p) begin
      if (mlen == DEPTH && g) movf = 1'b1;
      if (mlen == 0)                 mlen = 1;
      else if (g && mlen < DEPTH)    mlen++;
      hist.push_front(d);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    #1;
    bus.flush = 1'b0;
    bus.push  = 1'b0;
    bus.grow  = 1'b0;
    @(negedge clk);
    check_state(tag);
  endtask

  // Asynchronous clear in the low phase, held across one edge with a push
  // pending; the push must be lost.
  task automatic do_clear(input string tag);
    clear = 1'b1;
    #1;
    model_reset();
    check_state(tag);
    bus.push = 1'b1;
    bus.grow = 1'b1;
    bus.din  = 8'hA5;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.grow = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check_state({tag, ".held"});
  endtask

  task automatic read_at(input string tag, input int idx, input logic [WIDTH-1:0] exp);
    bus.rd_idx = LEN_W'(idx);
    #1;
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic probe_at(input string tag, input logic [WIDTH-1:0] p, input logic exp);
    bus.probe = p;
    #1;
    check(tag, 32'(bus.hit), 32'(exp));
  endtask

  initial begin
    clear      = 1'b1;
    bus.flush  = 1'b0;
    bus.push   = 1'b0;
    bus.grow   = 1'b0;
    bus.din    = '0;
    bus.rd_idx = '0;
    bus.probe  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("reset");
    clear = 1'b0;

    // Fill to full.
    step("fill0", 1'b0, 1'b1, 1'b1, 8'h11);
    step("fill1", 1'b0, 1'b1, 1'b1, 8'h22);
    step("fill2", 1'b0, 1'b1, 1'b1, 8'h33);
    step("fill3", 1'b0, 1'b1, 1'b1, 8'h44);
    check("fill.full", 32'(bus.full), 32'd1);
    read_at("fill.rd0", 0, 8'h44);
    read_at("fill.rd3", 3, 8'h11);

    // Overflow: one-cycle ovf pulse, length stays at DEPTH.
    step("ovf", 1'b0, 1'b1, 1'b1, 8'h55);
    check("ovf.pulse", 32'(bus.ovf), 32'd1);
    check("ovf.len",   32'(bus.len), 32'd4);
    read_at("ovf.rd3", 3, 8'h22);
    step("ovf.after", 1'b0, 1'b0, 1'b0, 8'h00);
    check("ovf.gone", 32'(bus.ovf), 32'd0);

    // Move without grow on a 3-long body.
    step("mv.flush", 1'b1, 1'b0, 1'b0, 8'h00);
    step("mv0", 1'b0, 1'b1, 1'b1, 8'h11);
    step("mv1", 1'b0, 1'b1, 1'b1, 8'h22);
    step("mv2", 1'b0, 1'b1, 1'b1, 8'h33);
    step("mv3", 1'b0, 1'b1, 1'b0, 8'h44);
    check("mv.len", 32'(bus.len), 32'd3);
    read_at("mv.rd0", 0, 8'h44);
    read_at("mv.rd2", 2, 8'h22);
    read_at("mv.rd3", 3, 8'h00);

    // Probe: valid entry hits, stale entry beyond len does not.
    probe_at("probe.22", 8'h22, 1'b1);
    probe_at("probe.11", 8'h11, 1'b0);

    // Flush beats push; next push without grow starts a 1-long body.
    step("fl.push", 1'b1, 1'b1, 1'b0, 8'h77);
    check("fl.len",  32'(bus.len),  32'd0);
    check("fl.head", 32'(bus.head), 32'd0);
    step("fl.next", 1'b0, 1'b1, 1'b0, 8'h77);
    check("fl.nlen",  32'(bus.len),  32'd1);
    check("fl.nhead", 32'(bus.head), 32'h77);

    // Asynchronous clear mid-run with a populated bank.
    step("pre.clr0", 1'b0, 1'b1, 1'b1, 8'h66);
    step("pre.clr1", 1'b0, 1'b1, 1'b1, 8'h99);
    do_clear("clr");

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(39) == 0) begin
        do_clear($sformatf("rclr%0d", n));
      end else begin
        step($sformatf("r%0d", n),
             ($urandom_range(11) == 0),
             ($urandom_range(3) != 0),
             1'($urandom),
             WIDTH'($urandom_range(15)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
